bird_motion_ctrl_param: RTL and testbench

//   Parametrised vertical-motion controller for the player bird. Tracks the bird's row on a

---
 rtl/bird_motion_ctrl_param.sv | 161 ++++++++++++++++
 tb/tb_bird_motion_ctrl_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : bird_motion_ctrl_param
// Brief    : Vertical-motion controller for the player bird: gravity divider,
//            edge-detected flap, ceiling mode, pause, crash and restart.
// Revision : 1.0 - initial release
// ============================================================================
module bird_motion_ctrl_param #(
    parameter int ROWS      = 8,
    parameter int START_ROW = 4,
    parameter int FLAP_ROWS = 1,
    parameter int FALL_DIV  = 1,
    parameter int CEIL_KILL = 1
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    tick,
    input  logic                    key,
    input  logic                    crash,
    input  logic                    restart,
    output logic [ROWS-1:0]         position,
    output logic [$clog2(ROWS)-1:0] row,
    output logic                    playing,
    output logic                    gameOver,
    output logic                    crashed
);

    localparam int c_RW = $clog2(ROWS);
    localparam int c_CW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;

    localparam logic [c_RW-1:0] c_START    = c_RW'(START_ROW);
    localparam logic [c_RW-1:0] c_GROUND   = c_RW'(ROWS - 1);
    localparam logic [c_RW:0]   c_FLAP     = (c_RW + 1)'(FLAP_ROWS);
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(FALL_DIV - 1);
    localparam logic [ROWS-1:0] c_ONE      = {{(ROWS - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_RW-1:0] r_row;
    logic [c_RW-1:0] w_row_nxt;
    logic            r_oob;
    logic            w_oob_nxt;
    logic [c_CW-1:0] r_fall_cnt;
    logic [c_CW-1:0] w_fall_cnt_nxt;
    logic            r_flap_pend;
    logic            w_flap_pend_nxt;
    logic            r_key_q;
    logic            r_crashed;
    logic            w_crashed_nxt;

    logic            w_key_edge;
    logic [c_RW:0]   w_flap_row;

    assign w_key_edge = key & ~r_key_q;
    // One extra bit so an overshoot above row 0 shows up as a set MSB.
    assign w_flap_row = {1'b0, r_row} - c_FLAP;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_row       <= c_START;
            r_oob       <= 1'b0;
            r_fall_cnt  <= '0;
            r_flap_pend <= 1'b0;
            r_key_q     <= 1'b0;
            r_crashed   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_oob       <= w_oob_nxt;
            r_fall_cnt  <= w_fall_cnt_nxt;
            r_flap_pend <= w_flap_pend_nxt;
            r_key_q     <= key;
            r_crashed   <= w_crashed_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_oob_nxt       = r_oob;
        w_fall_cnt_nxt  = r_fall_cnt;
        w_flap_pend_nxt = r_flap_pend;
        w_crashed_nxt   = r_crashed;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (crash) begin
                    w_state_nxt   = ST_OVER;
                    w_crashed_nxt = 1'b1;
                end else if (start && tick) begin
                    if (r_flap_pend) begin
                        w_flap_pend_nxt = 1'b0;
                        w_fall_cnt_nxt  = '0;
                        if (w_flap_row[c_RW]) begin
                            if (CEIL_KILL != 0) begin
                                w_state_nxt = ST_OVER;
                                w_oob_nxt   = 1'b1;
                            end else begin
                                w_row_nxt = '0;
                            end
                        end else begin
                            w_row_nxt = w_flap_row[c_RW-1:0];
                        end
                    end else if (r_fall_cnt == c_DIV_LAST) begin
                        w_fall_cnt_nxt = '0;
                        if (r_row == c_GROUND) begin
                            w_state_nxt = ST_OVER;
                            w_oob_nxt   = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_fall_cnt_nxt = r_fall_cnt + 1'b1;
                    end
                end

                // A fresh press must survive a same-cycle flap being consumed.
                if (w_key_edge) begin
                    w_flap_pend_nxt = 1'b1;
                end
            end

            ST_OVER: begin
                if (restart) begin
                    w_state_nxt     = ST_IDLE;
                    w_row_nxt       = c_START;
                    w_oob_nxt       = 1'b0;
                    w_fall_cnt_nxt  = '0;
                    w_flap_pend_nxt = 1'b0;
                    w_crashed_nxt   = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign position = r_oob ? '0 : (c_ONE << r_row);
    assign row      = r_row;
    assign playing  = (r_state == ST_PLAY);
    assign gameOver = (r_state == ST_OVER);
    assign crashed  = r_crashed;

endmodule
`default_nettype wire

// File: tb/tb_bird_motion_ctrl_param.sv
`default_nettype none
// Directed bench: three parameterisations share one stimulus set; each
// scenario task checks the instance it targets.
module tb_bird_motion_ctrl_param;

    logic Clock = 1'b0;
    logic reset, start, tick, key, crash, restart;

    logic [7:0] pos_a, pos_b, pos_c;
    logic [2:0] row_a, row_b, row_c;
    logic       play_a, play_b, play_c;
    logic       over_a, over_b, over_c;
    logic       crsh_a, crsh_b, crsh_c;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    // defaults
    bird_motion_ctrl_param u_dut_a (
        .Clock(Clock), .reset(reset), .start(start), .tick(tick), .key(key),
        .crash(crash), .restart(restart), .position(pos_a), .row(row_a),
        .playing(play_a), .gameOver(over_a), .crashed(crsh_a)
    );

    bird_motion_ctrl_param #(.ROWS(8), .START_ROW(1), .FLAP_ROWS(2), .FALL_DIV(3), .CEIL_KILL(1)) u_dut_b (
        .Clock(Clock), .reset(reset), .start(start), .tick(tick), .key(key),
        .crash(crash), .restart(restart), .position(pos_b), .row(row_b),
        .playing(play_b), .gameOver(over_b), .crashed(crsh_b)
    );

    bird_motion_ctrl_param #(.ROWS(8), .START_ROW(1), .FLAP_ROWS(2), .FALL_DIV(3), .CEIL_KILL(0)) u_dut_c (
        .Clock(Clock), .reset(reset), .start(start), .tick(tick), .key(key),
        .crash(crash), .restart(restart), .position(pos_c), .row(row_c),
        .playing(play_c), .gameOver(over_c), .crashed(crsh_c)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic apply_reset();
        start = 0; tick = 0; key = 0; crash = 0; restart = 0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (row_a !== 3'd4 || pos_a !== 8'h10 || play_a !== 0 || over_a !== 0 || crsh_a !== 0) begin
            errors++;
            $display("FAIL reset_a: row=%0d pos=%h p/o/c=%b%b%b, required row=4 pos=10 p/o/c=000",
                     row_a, pos_a, play_a, over_a, crsh_a);
        end
        checks++;
        if (row_b !== 3'd1 || pos_b !== 8'h02) begin
            errors++;
            $display("FAIL reset_b: row=%0d pos=%h, required row=1 pos=02", row_b, pos_b);
        end
    endtask

    task automatic test_fall();
        logic [2:0] exp_row;
        apply_reset();
        start = 1'b1;
        step();
        checks++;
        if (play_a !== 1'b1) begin
            errors++;
            $display("FAIL fall_start: playing=%b, required 1", play_a);
        end
        for (int i = 0; i < 3; i++) begin
            repeat (3) step();
            pulse_tick();
            exp_row = 3'(5 + i);
            checks++;
            if (row_a !== exp_row || pos_a !== (8'h01 << exp_row) || over_a !== 1'b0) begin
                errors++;
                $display("FAIL fall_row%0d: row=%0d pos=%h over=%b, required row=%0d over=0",
                         i, row_a, pos_a, over_a, exp_row);
            end
        end
        repeat (3) step();
        pulse_tick();
        checks++;
        if (over_a !== 1 || pos_a !== 8'h00 || crsh_a !== 0 || row_a !== 3'd7 || play_a !== 0) begin
            errors++;
            $display("FAIL fall_ground: over=%b pos=%h crashed=%b row=%0d playing=%b, required 1 00 0 7 0",
                     over_a, pos_a, crsh_a, row_a, play_a);
        end
    endtask

    task automatic test_fall_div();
        logic [2:0] exp_rows [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        apply_reset();
        start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            checks++;
            if (row_b !== exp_rows[i]) begin
                errors++;
                $display("FAIL div_tick%0d: row=%0d, required %0d", i, row_b, exp_rows[i]);
            end
        end
        start = 1'b0;
        repeat (5) begin
            step();
            pulse_tick();
        end
        checks++;
        if (row_b !== 3'd2 || play_b !== 1'b1 || over_b !== 1'b0) begin
            errors++;
            $display("FAIL div_pause: row=%0d playing=%b over=%b, required 2 1 0", row_b, play_b, over_b);
        end
        start = 1'b1;
        pulse_tick();
        checks++;
        if (row_b !== 3'd2) begin
            errors++;
            $display("FAIL div_resume1: row=%0d, required 2", row_b);
        end
        pulse_tick();
        checks++;
        if (row_b !== 3'd3) begin
            errors++;
            $display("FAIL div_resume2: row=%0d, required 3", row_b);
        end
    endtask

    task automatic test_flap();
        apply_reset();
        start = 1'b1;
        step();
        key = 1'b1;
        step();
        pulse_tick();
        checks++;
        if (over_b !== 1 || pos_b !== 8'h00 || row_b !== 3'd1 || crsh_b !== 0) begin
            errors++;
            $display("FAIL ceil_kill: over=%b pos=%h row=%0d crashed=%b, required 1 00 1 0",
                     over_b, pos_b, row_b, crsh_b);
        end
        checks++;
        if (row_c !== 3'd0 || pos_c !== 8'h01 || play_c !== 1) begin
            errors++;
            $display("FAIL ceil_clamp: row=%0d pos=%h playing=%b, required 0 01 1", row_c, pos_c, play_c);
        end
        repeat (10) pulse_tick();
        checks++;
        if (row_c !== 3'd3 || play_c !== 1) begin
            errors++;
            $display("FAIL key_held: row=%0d playing=%b, required 3 1", row_c, play_c);
        end
        key = 1'b0;
        step();
        key = 1'b1;
        step();
        pulse_tick();
        checks++;
        if (row_c !== 3'd1) begin
            errors++;
            $display("FAIL reflap: row=%0d, required 1", row_c);
        end
    endtask

    task automatic test_crash();
        apply_reset();
        start = 1'b1;
        step();
        key = 1'b1;
        step();
        pulse_tick();
        key = 1'b0;
        step();
        key = 1'b1;
        step();
        crash = 1'b1;
        tick  = 1'b1;
        step();
        crash = 1'b0;
        tick  = 1'b0;
        checks++;
        if (over_a !== 1 || crsh_a !== 1 || row_a !== 3'd3 || pos_a !== 8'h08 || play_a !== 0) begin
            errors++;
            $display("FAIL crash: over=%b crashed=%b row=%0d pos=%h playing=%b, required 1 1 3 08 0",
                     over_a, crsh_a, row_a, pos_a, play_a);
        end
        for (int i = 0; i < 20; i++) begin
            tick = i[0];
            step();
            checks++;
            if (over_a !== 1 || crsh_a !== 1 || row_a !== 3'd3 || pos_a !== 8'h08) begin
                errors++;
                $display("FAIL crash_hold%0d: over=%b crashed=%b row=%0d pos=%h, required 1 1 3 08",
                         i, over_a, crsh_a, row_a, pos_a);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_restart();
        start   = 1'b0;
        key     = 1'b0;
        restart = 1'b1;
        crash   = 1'b1;
        step();
        restart = 1'b0;
        crash   = 1'b0;
        checks++;
        if (play_a !== 0 || over_a !== 0 || crsh_a !== 0 || row_a !== 3'd4 || pos_a !== 8'h10) begin
            errors++;
            $display("FAIL restart: p/o/c=%b%b%b row=%0d pos=%h, required 000 4 10",
                     play_a, over_a, crsh_a, row_a, pos_a);
        end
        crash = 1'b1;
        step();
        crash = 1'b0;
        checks++;
        if (over_a !== 0 || crsh_a !== 0 || play_a !== 0) begin
            errors++;
            $display("FAIL idle_crash: over=%b crashed=%b playing=%b, required 000", over_a, crsh_a, play_a);
        end
        key = 1'b1;
        step();
        start = 1'b1;
        step();
        checks++;
        if (play_a !== 1'b1) begin
            errors++;
            $display("FAIL idle_start: playing=%b, required 1", play_a);
        end
        pulse_tick();
        checks++;
        if (row_a !== 3'd5) begin
            errors++;
            $display("FAIL idle_key: row=%0d, required 5", row_a);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if (play_a !== 1 || row_a !== 3'd5 || over_a !== 0) begin
            errors++;
            $display("FAIL play_restart: playing=%b row=%0d over=%b, required 1 5 0", play_a, row_a, over_a);
        end
    endtask

    task automatic test_async_reset();
        pulse_tick();
        checks++;
        if (row_a !== 3'd6) begin
            errors++;
            $display("FAIL pre_reset: row=%0d, required 6", row_a);
        end
        tick  = 1'b1;
        crash = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (row_a !== 3'd4 || pos_a !== 8'h10 || play_a !== 0 || over_a !== 0 || crsh_a !== 0) begin
            errors++;
            $display("FAIL async_reset: row=%0d pos=%h p/o/c=%b%b%b, required 4 10 000",
                     row_a, pos_a, play_a, over_a, crsh_a);
        end
        step();
        tick  = 1'b0;
        crash = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        step();
        checks++;
        if (row_a !== 3'd4 || play_a !== 0 || over_a !== 0) begin
            errors++;
            $display("FAIL post_reset: row=%0d playing=%b over=%b, required 4 0 0", row_a, play_a, over_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; start = 0; tick = 0; key = 0; crash = 0; restart = 0;
        test_reset();
        test_fall();
        test_fall_div();
        test_flap();
        test_crash();
        test_restart();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
